// File: rtl/reg_select_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : reg_select_scoreboard                                         |
// | Function : IR latch, Gra/Grb/Grc register select with one-hot enables,   |
// |            C-field sign extension and an optional register scoreboard    |
// |            (enabled by defining REG_SELECT_SCOREBOARD_EN).               |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module reg_select_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 16
) (
   input  logic                        clk,
   input  logic                        clr,
   input  logic [DATA_W-1:0]           IR_d,
   input  logic                        IRin,
   input  logic                        Gra,
   input  logic                        Grb,
   input  logic                        Grc,
   input  logic                        Rin,
   input  logic                        Rout,
   input  logic                        BAout,
   input  logic                        mark_busy,
   input  logic                        wb_done,
   input  logic [$clog2(NUM_REGS)-1:0] wb_idx,
   output logic [DATA_W-1:0]           IR_q,
   output logic [DATA_W-1:0]           C_sign_extended,
   output logic [$clog2(NUM_REGS)-1:0] sel_idx,
   output logic [NUM_REGS-1:0]         R_in,
   output logic [NUM_REGS-1:0]         R_out,
   output logic [NUM_REGS-1:0]         busy,
   output logic                        stall
);

   localparam int SEL_W = $clog2(NUM_REGS);
   localparam int CW    = 27 - 2*SEL_W;

   logic [DATA_W-1:0]   r_ir;
   logic [SEL_W-1:0]    w_ra;
   logic [SEL_W-1:0]    w_rb;
   logic [SEL_W-1:0]    w_rc;
   logic [SEL_W-1:0]    w_sel;
   logic                w_any_gr;
   logic                w_r0_base;
   logic                w_read;
   logic [NUM_REGS-1:0] w_onehot;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_ir <= '0;
      end else if (IRin) begin
         r_ir <= IR_d;
      end
   end

   assign w_ra = r_ir[26 -: SEL_W];
   assign w_rb = r_ir[26-SEL_W -: SEL_W];
   assign w_rc = r_ir[26-2*SEL_W -: SEL_W];

   assign w_any_gr = Gra | Grb | Grc;

   always_comb begin
      w_sel = '0;
      if (Gra) begin
         w_sel = w_ra;
      end else if (Grb) begin
         w_sel = w_rb;
      end else if (Grc) begin
         w_sel = w_rc;
      end
   end

   assign w_onehot  = {{(NUM_REGS-1){1'b0}}, 1'b1} << w_sel;
   // R0 used as a base register reads as zero, so it neither drives nor stalls.
   assign w_r0_base = BAout & (w_sel == '0);
   assign w_read    = (Rout | BAout) & w_any_gr & ~w_r0_base;

   assign IR_q            = r_ir;
   assign sel_idx         = w_sel;
   assign R_in            = (Rin & w_any_gr) ? w_onehot : '0;
   assign R_out           = w_read ? w_onehot : '0;
   assign C_sign_extended = {{(DATA_W-CW){r_ir[CW-1]}}, r_ir[CW-1:0]};

`ifdef REG_SELECT_SCOREBOARD_EN
   logic [NUM_REGS-1:0] r_busy;

   // The set is written after the clear so a same-index collision leaves it busy.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         r_busy <= '0;
      end else begin
         if (wb_done) begin
            r_busy[wb_idx] <= 1'b0;
         end
         if (mark_busy) begin
            r_busy[w_ra] <= 1'b1;
         end
      end
   end

   assign busy  = r_busy;
   assign stall = w_read & r_busy[w_sel];
`else
   logic w_unused_sb;

   assign w_unused_sb = &{1'b0, mark_busy, wb_done, wb_idx};
   assign busy        = '0;
   assign stall       = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_select_scoreboard.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_reg_select_scoreboard                                      |
// | Function : Directed self-checking bench for reg_select_scoreboard at     |
// |            NUM_REGS=16 and NUM_REGS=8.                                   |
// | Revision : 1.0                                                          |
// +--------------------------------------------------------------------------+
module tb_reg_select_scoreboard;

`ifdef REG_SELECT_SCOREBOARD_EN
   localparam bit c_SB = 1'b1;
`else
   localparam bit c_SB = 1'b0;
`endif

   logic        clk;
   logic        clr;
   logic [31:0] IR_d;
   logic        IRin, Gra, Grb, Grc, Rin, Rout, BAout, mark_busy, wb_done;
   logic [3:0]  wb_idx;
   logic [31:0] IR_q, C_sign_extended;
   logic [3:0]  sel_idx;
   logic [15:0] R_in, R_out, busy;
   logic        stall;

   logic [31:0] IR_d8;
   logic        IRin8, Gra8, Grb8, Grc8, Rin8, Rout8;
   logic [31:0] IR_q8, C8;
   logic [2:0]  sel8;
   logic [7:0]  R_in8, R_out8, busy8;
   logic        stall8;

   int n_tests = 0;
   int n_fail  = 0;

   reg_select_scoreboard #(.DATA_W(32), .NUM_REGS(16)) u_dut (
      .clk(clk), .clr(clr), .IR_d(IR_d), .IRin(IRin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .Rin(Rin), .Rout(Rout), .BAout(BAout),
      .mark_busy(mark_busy), .wb_done(wb_done), .wb_idx(wb_idx),
      .IR_q(IR_q), .C_sign_extended(C_sign_extended), .sel_idx(sel_idx),
      .R_in(R_in), .R_out(R_out), .busy(busy), .stall(stall)
   );

   reg_select_scoreboard #(.DATA_W(32), .NUM_REGS(8)) u_dut8 (
      .clk(clk), .clr(clr), .IR_d(IR_d8), .IRin(IRin8),
      .Gra(Gra8), .Grb(Grb8), .Grc(Grc8),
      .Rin(Rin8), .Rout(Rout8), .BAout(1'b0),
      .mark_busy(1'b0), .wb_done(1'b0), .wb_idx(3'd0),
      .IR_q(IR_q8), .C_sign_extended(C8), .sel_idx(sel8),
      .R_in(R_in8), .R_out(R_out8), .busy(busy8), .stall(stall8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_ir(input logic [31:0] v);
      IR_d = v;
      IRin = 1'b1;
      tick();
      IRin = 1'b0;
   endtask

   task automatic set_ctl(input logic a, input logic b, input logic c,
                          input logic ri, input logic ro, input logic ba);
      Gra = a; Grb = b; Grc = c; Rin = ri; Rout = ro; BAout = ba;
      #1;
   endtask

   initial begin
      clr = 1'b1; IR_d = '0; IRin = 0; Gra = 0; Grb = 0; Grc = 0;
      Rin = 0; Rout = 0; BAout = 0; mark_busy = 0; wb_done = 0; wb_idx = '0;
      IR_d8 = '0; IRin8 = 0; Gra8 = 0; Grb8 = 0; Grc8 = 0; Rin8 = 0; Rout8 = 0;
      tick();
      check_val("rst_ir",    IR_q, 32'h0);
      check_val("rst_c",     C_sign_extended, 32'h0);
      check_val("rst_busy",  busy, 32'h0);
      check_val("rst_stall", stall, 32'h0);
      check_val("rst_sel",   sel_idx, 32'h0);
      check_val("rst_rin",   R_in, 32'h0);
      check_val("rst_rout",  R_out, 32'h0);
      clr = 1'b0;

      // 0x0A9C0005: Ra=IR[26:23]=5, IR[18]=1 so the C field is negative.
      load_ir(32'h0A9C_0005);
      set_ctl(1, 0, 0, 1, 0, 0);
      check_val("ir_load", IR_q, 32'h0A9C_0005);
      check_val("rin_ra5", R_in, 32'h0000_0020);
      check_val("c_neg",   C_sign_extended, 32'hFFFC_0005);
      set_ctl(0, 0, 0, 1, 1, 0);
      check_val("nogr_rin",  R_in, 32'h0);
      check_val("nogr_rout", R_out, 32'h0);
      check_val("nogr_sel",  sel_idx, 32'h0);

      // Ra=1, C=5
      set_ctl(0, 0, 0, 0, 0, 0);
      load_ir(32'h0080_0005);
      set_ctl(1, 0, 0, 1, 0, 0);
      check_val("rin_ra1", R_in, 32'h0000_0002);
      check_val("c_pos5",  C_sign_extended, 32'h0000_0005);

      IRin = 1'b1; IR_d = 32'h0000_0000;
      #1;
      check_val("ir_hold_pre_edge", IR_q, 32'h0080_0005);
      IRin = 1'b0;

      load_ir(32'h0007_FFFF);
      check_val("c_allones", C_sign_extended, 32'hFFFF_FFFF);
      load_ir(32'h0003_FFFF);
      check_val("c_maxpos", C_sign_extended, 32'h0003_FFFF);

      // Ra=3, Rb=5: Gra outranks Grb
      load_ir(32'h01A8_0000);
      set_ctl(1, 1, 0, 0, 1, 0);
      check_val("prio_sel",  sel_idx, 32'd3);
      check_val("prio_rout", R_out, 32'h0000_0008);
      check_val("prio_rin",  R_in, 32'h0);
      set_ctl(0, 1, 1, 0, 1, 0);
      check_val("grb_sel", sel_idx, 32'd5);

      // Ra=3, Rb=0: R0 as base address reads as zero, plain Rout still selects it
      load_ir(32'h0180_0000);
      set_ctl(0, 1, 0, 0, 0, 1);
      check_val("ba_r0_rout",  R_out, 32'h0);
      check_val("ba_r0_stall", stall, 32'h0);
      set_ctl(0, 1, 0, 0, 1, 0);
      check_val("rout_r0", R_out, 32'h0000_0001);

      // Ra=4, Rc=4
      set_ctl(0, 0, 0, 0, 0, 0);
      load_ir(32'h0202_0000);
      mark_busy = 1'b1;
      tick();
      mark_busy = 1'b0;
      check_val("busy_set", busy, c_SB ? 32'h0000_0010 : 32'h0);
      set_ctl(0, 0, 1, 0, 1, 0);
      check_val("grc_sel",   sel_idx, 32'd4);
      check_val("stall_rc4", stall, {31'd0, c_SB});
      wb_done = 1'b1; wb_idx = 4'd4;
      #1;
      check_val("stall_no_bypass", stall, {31'd0, c_SB});
      tick();
      wb_done = 1'b0;
      check_val("stall_cleared", stall, 32'h0);
      check_val("busy_cleared",  busy, 32'h0);

      mark_busy = 1'b1; wb_done = 1'b1; wb_idx = 4'd4;
      tick();
      mark_busy = 1'b0; wb_done = 1'b0;
      check_val("set_wins", busy, c_SB ? 32'h0000_0010 : 32'h0);

      // Clear of a different index leaves busy[4]
      wb_done = 1'b1; wb_idx = 4'd3;
      tick();
      wb_done = 1'b0;
      check_val("clr_other_idx", busy, c_SB ? 32'h0000_0010 : 32'h0);

      #2 clr = 1'b1;
      #1;
      check_val("async_busy", busy, 32'h0);
      check_val("async_ir",   IR_q, 32'h0);
      check_val("async_stall", stall, 32'h0);
      clr = 1'b0;
      wb_done = 1'b1; wb_idx = 4'd4;
      tick();
      wb_done = 1'b0;
      check_val("post_clr_busy", busy, 32'h0);

      // R0 busy: BAout suppresses the stall, Rout does not
      set_ctl(0, 0, 0, 0, 0, 0);
      load_ir(32'h0000_0000);
      mark_busy = 1'b1;
      tick();
      mark_busy = 1'b0;
      set_ctl(1, 0, 0, 0, 0, 1);
      check_val("ba_r0_busy_stall", stall, 32'h0);
      set_ctl(1, 0, 0, 0, 1, 0);
      check_val("rout_r0_busy_stall", stall, {31'd0, c_SB});
      set_ctl(0, 0, 0, 0, 0, 0);

      // NUM_REGS=8: Ra=IR[26:24]=5, Rb=IR[23:21]=2, Rc=IR[20:18]=6, CW=21
      IR_d8 = 32'h0558_0000; IRin8 = 1'b1;
      tick();
      IRin8 = 1'b0;
      Gra8 = 1; Rin8 = 1;
      #1;
      check_val("n8_ra_sel", sel8, 32'd5);
      check_val("n8_ra_rin", R_in8, 32'h20);
      Gra8 = 0; Rin8 = 0; Grb8 = 1;
      #1;
      check_val("n8_rb_sel", sel8, 32'd2);
      Grb8 = 0; Grc8 = 1; Rout8 = 1;
      #1;
      check_val("n8_rc_rout", R_out8, 32'h40);
      check_val("n8_c_neg",   C8, 32'hFFF8_0000);
      check_val("n8_busy",    busy8, 32'h0);
      Grc8 = 0; Rout8 = 0;
      IR_d8 = 32'h000F_FFFF; IRin8 = 1'b1;
      tick();
      check_val("n8_c_pos", C8, 32'h000F_FFFF);
      IR_d8 = 32'h001F_FFFF;
      tick();
      IRin8 = 1'b0;
      check_val("n8_c_ones", C8, 32'hFFFF_FFFF);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
